// File: rtl/mcpu_mem_pkg.sv
// rtl/mcpu_mem_pkg.sv - shared state encoding, wait-counter width and error causes for the DRAM wait-state controller
package mcpu_mem_pkg;

  // Wait counters load READ_WAIT / WRITE_WAIT (0..15), so four bits never wrap
  localparam int CNT_BITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_WR_WAIT,
    ST_WR_DONE,
    ST_ERR_DONE
  } dram_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_BOTH,
    ERR_RANGE
  } err_cause_e;

  // Conflicting read+write wins over a range fault so both are reported the same way
  function automatic err_cause_e classify(input logic re, input logic we, input logic in_range);
    if (re && we) return ERR_BOTH;
    if (!in_range) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/mcpu_dram_ws_if.sv
// rtl/mcpu_dram_ws_if.sv - request/response handshake bundle between a bus master and the DRAM controller
interface mcpu_dram_ws_if #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 14
);
  logic [ADDR_BITS-1:0]   dram_addr;
  logic [DATA_BITS/8-1:0] dram_be;
  logic                   dram_we;
  logic                   dram_re;
  logic                   dram_ready;
  logic                   dram_busy;
  logic                   dram_err;

  modport master (
    output dram_addr, dram_be, dram_we, dram_re,
    input  dram_ready, dram_busy, dram_err
  );

  modport slave (
    input  dram_addr, dram_be, dram_we, dram_re,
    output dram_ready, dram_busy, dram_err
  );
endinterface

// File: rtl/mcpu_dram_array.sv
// rtl/mcpu_dram_array.sv - DEPTH x DATA_BITS storage with byte-lane writes and a registered read port
module mcpu_dram_array #(
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 16384,
  parameter int AW        = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [DATA_BITS-1:0]   wr_data_i,
  input  logic [DATA_BITS/8-1:0] wr_be_i,
  input  logic                   rd_en_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic [DATA_BITS-1:0]   rd_data_o
);
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] rd_data_q;

  // Storage is deliberately not reset; only enabled byte lanes are updated
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < DATA_BITS / 8; i++) begin
        if (wr_be_i[i]) mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  // Read register captures the addressed word at the request edge and clears on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/mcpu_dram_ws.sv
// rtl/mcpu_dram_ws.sv - DRAM controller with programmable read/write wait states on a shared data bus
module mcpu_dram_ws
  import mcpu_mem_pkg::*;
#(
  parameter int DATA_BITS  = 16,
  parameter int ADDR_BITS  = 14,
  parameter int DEPTH      = 2 ** ADDR_BITS,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mcpu_dram_ws_if.slave        bus,
  inout  wire [DATA_BITS-1:0]  data_bus
);
  localparam int NB = DATA_BITS / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

  dram_state_e          state_q;
  logic [CNT_BITS-1:0]  cnt_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 err_q;
  logic [AW-1:0]        wr_addr_q;
  logic [DATA_BITS-1:0] wr_data_q;
  logic [NB-1:0]        wr_be_q;

  logic                 in_range;
  logic                 req;
  logic                 rd_ok;
  logic                 wr_ok;
  err_cause_e           cause;
  logic                 arr_we_d;
  logic [AW-1:0]        arr_waddr_d;
  logic [DATA_BITS-1:0] arr_wdata_d;
  logic [NB-1:0]        arr_wbe_d;
  logic [DATA_BITS-1:0] rd_data;

  assign in_range = ({1'b0, bus.dram_addr} < DEPTH_W);
  assign cause    = classify(bus.dram_re, bus.dram_we, in_range);
  assign req      = (state_q == ST_IDLE) && (bus.dram_re || bus.dram_we);
  assign rd_ok    = req && (cause == ERR_NONE) && bus.dram_re;
  assign wr_ok    = req && (cause == ERR_NONE) && !bus.dram_re;

  // Zero write-wait commits straight from the bus at the request edge; otherwise from the latched copy
  always_comb begin
    arr_we_d    = 1'b0;
    arr_waddr_d = wr_addr_q;
    arr_wdata_d = wr_data_q;
    arr_wbe_d   = wr_be_q;
    if (WRITE_WAIT == 0) begin
      arr_we_d    = wr_ok;
      arr_waddr_d = bus.dram_addr[AW-1:0];
      arr_wdata_d = data_bus;
      arr_wbe_d   = bus.dram_be;
    end else begin
      arr_we_d = (state_q == ST_WR_WAIT) && (cnt_q == CNT_BITS'(1));
    end
    arr_we_d = arr_we_d && reset;
  end

  // Transaction sequencer: decodes requests in IDLE, counts wait states, emits one-cycle completion strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            busy_q <= 1'b1;
            if (cause != ERR_NONE) begin
              state_q <= ST_ERR_DONE;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end else if (bus.dram_re) begin
              if (READ_WAIT == 0) begin
                state_q <= ST_RD_DONE;
                ready_q <= 1'b1;
              end else begin
                state_q <= ST_RD_WAIT;
                cnt_q   <= CNT_BITS'(READ_WAIT);
              end
            end else begin
              wr_addr_q <= bus.dram_addr[AW-1:0];
              wr_data_q <= data_bus;
              wr_be_q   <= bus.dram_be;
              if (WRITE_WAIT == 0) begin
                state_q <= ST_WR_DONE;
                ready_q <= 1'b1;
              end else begin
                state_q <= ST_WR_WAIT;
                cnt_q   <= CNT_BITS'(WRITE_WAIT);
              end
            end
          end
        end
        ST_RD_WAIT: begin
          cnt_q <= cnt_q - CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(1)) begin
            state_q <= ST_RD_DONE;
            ready_q <= 1'b1;
          end
        end
        ST_WR_WAIT: begin
          cnt_q <= cnt_q - CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(1)) begin
            state_q <= ST_WR_DONE;
            ready_q <= 1'b1;
          end
        end
        ST_RD_DONE, ST_WR_DONE, ST_ERR_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  mcpu_dram_array #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (arr_we_d),
    .wr_addr_i (arr_waddr_d),
    .wr_data_i (arr_wdata_d),
    .wr_be_i   (arr_wbe_d),
    .rd_en_i   (rd_ok),
    .rd_addr_i (bus.dram_addr[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // The bus is only ours while the read is completing and the master still holds its request
  assign data_bus = ((state_q == ST_RD_DONE) && bus.dram_re) ? rd_data : {DATA_BITS{1'bz}};

  assign bus.dram_ready = ready_q;
  assign bus.dram_busy  = busy_q;
  assign bus.dram_err   = err_q;
endmodule

// File: tb/tb_mcpu_dram_ws.sv
// tb/tb_mcpu_dram_ws.sv - self-checking bench for mcpu_dram_ws with a word-array reference model
module tb_mcpu_dram_ws;
  localparam int RW_A    = 2;
  localparam int WW_A    = 1;
  localparam int RD_LAT  = RW_A + 1;
  localparam int WR_LAT  = WW_A + 1;
  localparam int ERR_LAT = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mcpu_dram_ws_if #(.DATA_BITS(16), .ADDR_BITS(14)) if_a ();
  mcpu_dram_ws_if #(.DATA_BITS(16), .ADDR_BITS(14)) if_b ();
  mcpu_dram_ws_if #(.DATA_BITS(16), .ADDR_BITS(14)) if_c ();

  tri1 [15:0]  bus_a;
  tri1 [15:0]  bus_b;
  tri1 [15:0]  bus_c;
  logic        tb_den [3];
  logic [15:0] tb_wd  [3];

  assign bus_a = tb_den[0] ? tb_wd[0] : 16'hzzzz;
  assign bus_b = tb_den[1] ? tb_wd[1] : 16'hzzzz;
  assign bus_c = tb_den[2] ? tb_wd[2] : 16'hzzzz;

  mcpu_dram_ws u_a (.clk(clk), .reset(reset), .bus(if_a), .data_bus(bus_a));
  mcpu_dram_ws #(.DEPTH(1024)) u_b (.clk(clk), .reset(reset), .bus(if_b), .data_bus(bus_b));
  mcpu_dram_ws #(.READ_WAIT(0), .WRITE_WAIT(0)) u_c (.clk(clk), .reset(reset), .bus(if_c), .data_bus(bus_c));

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mdl [logic [13:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  task automatic drive(input int sel, input logic [13:0] a, input logic [1:0] be, input logic we, input logic re);
    case (sel)
      0: begin if_a.dram_addr = a; if_a.dram_be = be; if_a.dram_we = we; if_a.dram_re = re; end
      1: begin if_b.dram_addr = a; if_b.dram_be = be; if_b.dram_we = we; if_b.dram_re = re; end
      default: begin if_c.dram_addr = a; if_c.dram_be = be; if_c.dram_we = we; if_c.dram_re = re; end
    endcase
  endtask

  task automatic sample(input int sel, output logic rdy, output logic bsy, output logic er, output logic [15:0] bv);
    case (sel)
      0: begin rdy = if_a.dram_ready; bsy = if_a.dram_busy; er = if_a.dram_err; bv = bus_a; end
      1: begin rdy = if_b.dram_ready; bsy = if_b.dram_busy; er = if_b.dram_err; bv = bus_b; end
      default: begin rdy = if_c.dram_ready; bsy = if_c.dram_busy; er = if_c.dram_err; bv = bus_c; end
    endcase
  endtask

  task automatic op(input int sel, input string tag, input logic we, input logic re, input logic [13:0] a,
                    input logic [15:0] d, input logic [1:0] be, input int exp_lat, input logic exp_err,
                    input logic exp_drive, input logic [15:0] exp_data);
    int cyc;
    logic rdy, bsy, er;
    logic [15:0] bv;
    tb_wd[sel]  = d;
    tb_den[sel] = we && !re;
    drive(sel, a, be, we, re);
    @(posedge clk);
    #1 tb_den[sel] = 1'b0;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 40) begin
      @(negedge clk);
      cyc++;
      sample(sel, rdy, bsy, er, bv);
      if (!rdy) begin
        chk({tag, "_wait_busy"}, 32'(bsy), 32'd1);
        chk({tag, "_wait_bus"}, 32'(bv), 32'hFFFF);
      end
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_done_busy"}, 32'(bsy), 32'd1);
    chk({tag, "_done_bus"}, 32'(bv), exp_drive ? 32'(exp_data) : 32'hFFFF);
    drive(sel, 14'd0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    sample(sel, rdy, bsy, er, bv);
    chk({tag, "_idle_ready"}, 32'(rdy), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bsy), 32'd0);
    chk({tag, "_idle_err"}, 32'(er), 32'd0);
    chk({tag, "_idle_bus"}, 32'(bv), 32'hFFFF);
  endtask

  initial begin
    logic rdy, bsy, er, exp_r;
    logic [15:0] bv, d;
    logic [13:0] a, addrs [6];
    logic [1:0] be;

    for (int i = 0; i < 3; i++) begin
      tb_den[i] = 1'b0;
      tb_wd[i]  = 16'h0;
      drive(i, 14'd0, 2'd0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample(i, rdy, bsy, er, bv);
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_busy", 32'(bsy), 32'd0);
      chk("rst_err", 32'(er), 32'd0);
      chk("rst_bus", 32'(bv), 32'hFFFF);
    end
    reset = 1'b1;
    @(negedge clk);

    op(0, "wr_beef", 1'b1, 1'b0, 14'h0010, 16'hBEEF, 2'b11, WR_LAT, 1'b0, 1'b0, 16'h0);
    mdl[14'h0010] = 16'hBEEF;
    op(0, "rd_beef", 1'b0, 1'b1, 14'h0010, 16'h0, 2'b00, RD_LAT, 1'b0, 1'b1, 16'hBEEF);
    op(0, "wr_1234", 1'b1, 1'b0, 14'h0010, 16'h1234, 2'b01, WR_LAT, 1'b0, 1'b0, 16'h0);
    mdl[14'h0010] = merge(mdl[14'h0010], 16'h1234, 2'b01);
    op(0, "rd_be34", 1'b0, 1'b1, 14'h0010, 16'h0, 2'b00, RD_LAT, 1'b0, 1'b1, 16'hBE34);
    op(0, "both", 1'b1, 1'b1, 14'h0010, 16'h0, 2'b11, ERR_LAT, 1'b1, 1'b0, 16'h0);
    op(0, "rd_after_both", 1'b0, 1'b1, 14'h0010, 16'h0, 2'b00, RD_LAT, 1'b0, 1'b1, mdl[14'h0010]);
    op(0, "wr_be0", 1'b1, 1'b0, 14'h0010, 16'h0000, 2'b00, WR_LAT, 1'b0, 1'b0, 16'h0);
    op(0, "rd_after_be0", 1'b0, 1'b1, 14'h0010, 16'h0, 2'b00, RD_LAT, 1'b0, 1'b1, 16'hBE34);

    op(1, "b_wr0", 1'b1, 1'b0, 14'h0000, 16'hA5A5, 2'b11, WR_LAT, 1'b0, 1'b0, 16'h0);
    op(1, "b_wr_top", 1'b1, 1'b0, 14'h03FF, 16'h3C3C, 2'b11, WR_LAT, 1'b0, 1'b0, 16'h0);
    op(1, "b_rd_oor", 1'b0, 1'b1, 14'h0400, 16'h0, 2'b00, ERR_LAT, 1'b1, 1'b0, 16'h0);
    op(1, "b_wr_oor", 1'b1, 1'b0, 14'h0400, 16'h1111, 2'b11, ERR_LAT, 1'b1, 1'b0, 16'h0);
    op(1, "b_rd0", 1'b0, 1'b1, 14'h0000, 16'h0, 2'b00, RD_LAT, 1'b0, 1'b1, 16'hA5A5);
    op(1, "b_rd_top", 1'b0, 1'b1, 14'h03FF, 16'h0, 2'b00, RD_LAT, 1'b0, 1'b1, 16'h3C3C);

    op(2, "c_wr", 1'b1, 1'b0, 14'h0003, 16'h0F0F, 2'b11, 1, 1'b0, 1'b0, 16'h0);
    drive(2, 14'h0003, 2'b00, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      sample(2, rdy, bsy, er, bv);
      exp_r = (k % 2) == 1;
      chk("c_hold_ready", 32'(rdy), 32'(exp_r));
      chk("c_hold_busy", 32'(bsy), 32'(exp_r));
      chk("c_hold_bus", 32'(bv), exp_r ? 32'h0F0F : 32'hFFFF);
    end
    drive(2, 14'd0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    op(0, "wr_pre", 1'b1, 1'b0, 14'h0001, 16'h7777, 2'b11, WR_LAT, 1'b0, 1'b0, 16'h0);
    mdl[14'h0001] = 16'h7777;
    tb_wd[0]  = 16'h5555;
    tb_den[0] = 1'b1;
    drive(0, 14'h0001, 2'b11, 1'b1, 1'b0);
    @(posedge clk);
    #1 tb_den[0] = 1'b0;
    sample(0, rdy, bsy, er, bv);
    chk("abort_pre_busy", 32'(bsy), 32'd1);
    #1 reset = 1'b0;
    #1 sample(0, rdy, bsy, er, bv);
    chk("abort_ready", 32'(rdy), 32'd0);
    chk("abort_busy", 32'(bsy), 32'd0);
    chk("abort_err", 32'(er), 32'd0);
    chk("abort_bus", 32'(bv), 32'hFFFF);
    drive(0, 14'd0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    op(0, "rd_after_abort", 1'b0, 1'b1, 14'h0001, 16'h0, 2'b00, RD_LAT, 1'b0, 1'b1, mdl[14'h0001]);

    for (int i = 0; i < 6; i++) begin
      addrs[i] = 14'($urandom_range(16'h3FFF, 16'h0100));
      d = 16'($urandom);
      op(0, "rnd_init", 1'b1, 1'b0, addrs[i], d, 2'b11, WR_LAT, 1'b0, 1'b0, 16'h0);
      mdl[addrs[i]] = d;
    end
    for (int i = 0; i < 24; i++) begin
      a = addrs[$urandom_range(5, 0)];
      if ($urandom_range(1, 0) == 1) begin
        d  = 16'($urandom);
        be = 2'($urandom);
        op(0, "rnd_wr", 1'b1, 1'b0, a, d, be, WR_LAT, 1'b0, 1'b0, 16'h0);
        mdl[a] = merge(mdl[a], d, be);
      end else begin
        op(0, "rnd_rd", 1'b0, 1'b1, a, 16'h0, 2'b00, RD_LAT, 1'b0, 1'b1, mdl[a]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mcpu_dram_ws.md
MCPU_DRAM_WS -- requirements
Module: mcpu_dram_ws

Interface
REQ-001 Parameter DATA_BITS, default 16: data word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_BITS, default 14: address width.
REQ-003 Parameter DEPTH, default 2**ADDR_BITS: implemented words; 1..2**ADDR_BITS.
REQ-004 Parameter READ_WAIT, default 2: read wait states, 0..15.
REQ-005 Parameter WRITE_WAIT, default 1: write wait states, 0..15.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 dram_addr  input  ADDR_BITS  word address, sampled at request edge.
REQ-009 data_bus  inout  DATA_BITS  shared bus; write data sampled at request edge, read data driven in RD_DONE.
REQ-010 dram_be  input  DATA_BITS/8  write byte enables, sampled at request edge; bit i gates bits 8i+7..8i.
REQ-011 dram_we  input  1  write request, level, held until dram_ready.
REQ-012 dram_re  input  1  read request, level, held until dram_ready.
REQ-013 dram_ready  output  1  one-cycle completion strobe.
REQ-014 dram_busy  output  1  high in every state except IDLE.
REQ-015 dram_err  output  1  high with dram_ready when the completing transaction was erroneous.

Function
REQ-016 States SHALL be IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE, ERR_DONE.
REQ-017 Request edge = rising edge in IDLE with dram_re or dram_we high; in any other state dram_re/dram_we SHALL be ignored.
REQ-018 Read request (re=1, we=0, addr<DEPTH) SHALL latch the array word into a read register at the request edge, then go to RD_WAIT with counter=READ_WAIT, or directly to RD_DONE if READ_WAIT=0.
REQ-019 RD_WAIT SHALL decrement the counter each edge and enter RD_DONE on the edge where counter reaches 0; dram_ready SHALL therefore be high in the cycle after edge N+READ_WAIT (N = request edge).
REQ-020 data_bus SHALL be driven from the read register only when state=RD_DONE and dram_re=1; otherwise high-Z.
REQ-021 Write request (we=1, re=0, addr<DEPTH) SHALL latch addr, data_bus and dram_be at the request edge; the bus may be released afterwards.
REQ-022 Write SHALL commit the enabled byte lanes to the array at edge N+WRITE_WAIT, entering WR_DONE on that edge; dram_be=0 completes normally with no array change.
REQ-023 RD_DONE, WR_DONE and ERR_DONE SHALL assert dram_ready for exactly one cycle and return to IDLE on the next edge.
REQ-024 A request still held in IDLE after DONE SHALL start a new transaction (back-to-back, one IDLE cycle between).
REQ-025 Error cases, re=1 and we=1 together or addr>=DEPTH: no array change, bus not driven, ERR_DONE entered at the request edge, dram_ready=dram_err=1 in the next cycle.
REQ-026 A read issued after a completed write to the same address SHALL return the written data.
REQ-027 Wait counter width SHALL be 4 bits; no wrap occurs since load values are 0..15.

Reset
REQ-028 reset low SHALL immediately force state=IDLE, counter=0, dram_ready=0, dram_busy=0, dram_err=0, read register=0, data_bus high-Z.
REQ-029 Reset during WR_WAIT SHALL abort the write with no array change; reset during WR_DONE SHALL leave the already committed write in place.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 State encoding, wait-counter width and error-cause constants SHALL live in shared package mcpu_mem_pkg.
REQ-032 Storage SHALL be sub-module mcpu_dram_array: DEPTH x DATA_BITS, byte-lane write enable, synchronous read.

Verification
REQ-033 Defaults; write 0xBEEF to 0x0010 with be=11 -> ready in the cycle after edge N+1, no err; then read 0x0010 -> ready after edge N+2, bus=0xBEEF in RD_DONE only.
REQ-034 Write 0x1234 with be=01 over 0xBEEF -> subsequent read returns 0xBE34.
REQ-035 re=1 and we=1 together -> dram_ready=dram_err=1 one cycle after the request edge, memory unchanged, bus high-Z throughout.
REQ-036 DEPTH=1024, read 0x0400 -> err strobe, bus never driven; write 0x0400 -> err strobe, 0x0000 unchanged.
REQ-037 READ_WAIT=0, WRITE_WAIT=0, dram_re held high continuously -> ready pulses every second cycle, busy toggles accordingly.
REQ-038 Write 0x5555 to 0x0001 with reset pulsed low in WR_WAIT -> all outputs 0 immediately, later read of 0x0001 returns its pre-write value.
